// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame-buffer AXI4-Lite responder:
// AXI response codes and the responder FSM state type.
package vga_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      RESP
   } fb_slv_state_t;

endpackage

// File: rtl/vga_fb_ram.sv
// Single-clock simple dual-port frame-buffer RAM with a registered,
// read-first read port. Contents are never reset.
module vga_fb_ram #(
   parameter int AXI_DATA_WIDTH = 64,
   parameter int MEM_DEPTH      = 1024
) (
   input  logic                         clk,
   input  logic                         wr_en_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] wr_addr_i,
   input  logic [AXI_DATA_WIDTH-1:0]    wr_data_i,
   input  logic                         rd_en_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] rd_addr_i,
   output logic [AXI_DATA_WIDTH-1:0]    rd_data_o
);

   logic [AXI_DATA_WIDTH-1:0] mem_q [MEM_DEPTH];
   logic [AXI_DATA_WIDTH-1:0] rd_data_q;

   // Both accesses use non-blocking updates, so a same-edge read sees the old word.
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/vga_axi_fb_slave.sv
// AXI4-Lite read-only responder serving frame-buffer words from an internal
// RAM, one outstanding transaction at a time, plus a word-addressed load port.
module vga_axi_fb_slave
   import vga_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int AXI_DATA_WIDTH = 64,
   parameter int MEM_DEPTH      = 1024
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [AXI_ADDR_WIDTH-1:0]    s_araddr_i,
   input  logic [2:0]                   s_arprot_i,
   input  logic                         s_arvalid_i,
   output logic                         s_arrdy_o,
   output logic [AXI_DATA_WIDTH-1:0]    s_rdata_o,
   output logic [1:0]                   s_rresp_o,
   output logic                         s_rvalid_o,
   input  logic                         s_rrdy_i,
   input  logic                         ld_en_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] ld_addr_i,
   input  logic [AXI_DATA_WIDTH-1:0]    ld_data_i
);

   localparam int OFFS_W = $clog2(AXI_DATA_WIDTH / 8);
   localparam int IDX_W  = AXI_ADDR_WIDTH - OFFS_W;
   localparam int MEM_AW = $clog2(MEM_DEPTH);

   fb_slv_state_t             state_q, state_d;
   logic                      arrdy_q, arrdy_d;
   logic                      in_range_q, in_range_d;
   logic [AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]                rresp_q, rresp_d;

   logic [IDX_W-1:0]          ar_idx;
   logic                      ar_in_range;
   logic                      ar_hs;
   logic [AXI_DATA_WIDTH-1:0] ram_rdata;
   logic                      unused_ok;

   assign ar_idx      = s_araddr_i[AXI_ADDR_WIDTH-1:OFFS_W];
   assign ar_in_range = (ar_idx < IDX_W'(MEM_DEPTH));
   assign ar_hs       = s_arvalid_i & arrdy_q;
   assign unused_ok   = ^{s_arprot_i, s_araddr_i[OFFS_W-1:0]};

   // The RAM is read on the AR handshake edge itself, so a load to the
   // same word on that edge leaves the returned data at its old value.
   vga_fb_ram #(
      .AXI_DATA_WIDTH (AXI_DATA_WIDTH),
      .MEM_DEPTH      (MEM_DEPTH)
   ) u_ram (
      .clk       (clk),
      .wr_en_i   (ld_en_i),
      .wr_addr_i (ld_addr_i),
      .wr_data_i (ld_data_i),
      .rd_en_i   (ar_hs & ar_in_range),
      .rd_addr_i (ar_idx[MEM_AW-1:0]),
      .rd_data_o (ram_rdata)
   );

   always_comb begin
      state_d    = state_q;
      in_range_d = in_range_q;
      rdata_d    = rdata_q;
      rresp_d    = rresp_q;
      case (state_q)
         IDLE: begin
            if (ar_hs) begin
               state_d    = READ;
               in_range_d = ar_in_range;
            end
         end
         READ: begin
            state_d = RESP;
            rdata_d = in_range_q ? ram_rdata : '0;
            rresp_d = in_range_q ? RESP_OKAY : RESP_DECERR;
         end
         RESP: begin
            if (s_rrdy_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      arrdy_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         arrdy_q    <= 1'b0;
         in_range_q <= 1'b0;
         rdata_q    <= '0;
         rresp_q    <= RESP_OKAY;
      end else begin
         state_q    <= state_d;
         arrdy_q    <= arrdy_d;
         in_range_q <= in_range_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
      end
   end

   assign s_arrdy_o  = arrdy_q;
   assign s_rvalid_o = (state_q == RESP);
   assign s_rdata_o  = rdata_q;
   assign s_rresp_o  = rresp_q;

endmodule

// File: tb/tb_vga_axi_fb_slave.sv
// Directed, table-driven bench for vga_axi_fb_slave.
module tb_vga_axi_fb_slave;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] DECERR = 2'b11;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] s_araddr_i;
   logic [2:0]  s_arprot_i;
   logic        s_arvalid_i;
   logic        s_arrdy_o;
   logic [63:0] s_rdata_o;
   logic [1:0]  s_rresp_o;
   logic        s_rvalid_o;
   logic        s_rrdy_i;
   logic        ld_en_i;
   logic [9:0]  ld_addr_i;
   logic [63:0] ld_data_i;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   vga_axi_fb_slave #(
      .AXI_ADDR_WIDTH (32),
      .AXI_DATA_WIDTH (64),
      .MEM_DEPTH      (1024)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_araddr_i  (s_araddr_i),
      .s_arprot_i  (s_arprot_i),
      .s_arvalid_i (s_arvalid_i),
      .s_arrdy_o   (s_arrdy_o),
      .s_rdata_o   (s_rdata_o),
      .s_rresp_o   (s_rresp_o),
      .s_rvalid_o  (s_rvalid_o),
      .s_rrdy_i    (s_rrdy_i),
      .ld_en_i     (ld_en_i),
      .ld_addr_i   (ld_addr_i),
      .ld_data_i   (ld_data_i)
   );

   typedef struct {
      logic [31:0] addr;
      logic [63:0] data;
      logic [1:0]  resp;
   } vec_t;

   vec_t vecs [8];

   task automatic chk1(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chkd(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkr(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic load(input logic [9:0] a, input logic [63:0] d);
      ld_en_i   = 1'b1;
      ld_addr_i = a;
      ld_data_i = d;
      @(posedge clk); #1;
      ld_en_i   = 1'b0;
   endtask

   // One read; optionally loads a word on the AR handshake edge and
   // stalls rready for 'stall' cycles after rvalid rises.
   task automatic rd_txn(input logic [31:0] addr, input int stall,
                         input bit ld_same, input logic [9:0] la, input logic [63:0] ld_d,
                         input logic [63:0] exp_d, input logic [1:0] exp_r);
      int n;
      n = 0;
      s_rrdy_i    = (stall == 0);
      s_araddr_i  = addr;
      s_arvalid_i = 1'b1;
      while (s_arrdy_o !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk1("arready_wait", n < 20, 1'b1);
      if (ld_same) begin
         ld_en_i   = 1'b1;
         ld_addr_i = la;
         ld_data_i = ld_d;
      end
      @(posedge clk); #1;
      s_arvalid_i = 1'b0;
      ld_en_i     = 1'b0;
      chk1("rvalid_after_hs", s_rvalid_o, 1'b0);
      chk1("arready_after_hs", s_arrdy_o, 1'b0);
      @(posedge clk); #1;
      chk1("rvalid_e1", s_rvalid_o, 1'b1);
      chkd("rdata", s_rdata_o, exp_d);
      chkr("rresp", s_rresp_o, exp_r);
      for (int i = 0; i < stall; i++) begin
         @(posedge clk); #1;
         chk1("hold_rvalid", s_rvalid_o, 1'b1);
         chk1("hold_arready", s_arrdy_o, 1'b0);
         chkd("hold_rdata", s_rdata_o, exp_d);
         chkr("hold_rresp", s_rresp_o, exp_r);
      end
      s_rrdy_i = 1'b1;
      @(posedge clk); #1;
      chk1("rvalid_after_rhs", s_rvalid_o, 1'b0);
      chk1("arready_after_rhs", s_arrdy_o, 1'b1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{32'h0000_0028, 64'hDEAD_BEEF_0123_4567, OKAY};
      vecs[1] = '{32'h0000_002B, 64'hDEAD_BEEF_0123_4567, OKAY};
      vecs[2] = '{32'h0000_2000, 64'h0,                   DECERR};
      vecs[3] = '{32'h0000_0028, 64'hDEAD_BEEF_0123_4567, OKAY};
      vecs[4] = '{32'h0000_0000, 64'h0011_2233_4455_6677, OKAY};
      vecs[5] = '{32'h0000_1FFF, 64'hA5A5_5A5A_F00D_CAFE, OKAY};
      vecs[6] = '{32'hFFFF_FFF8, 64'h0,                   DECERR};
      vecs[7] = '{32'h0000_002F, 64'hDEAD_BEEF_0123_4567, OKAY};

      rst_n       = 1'b0;
      s_araddr_i  = '0;
      s_arprot_i  = 3'b010;
      s_arvalid_i = 1'b0;
      s_rrdy_i    = 1'b0;
      ld_en_i     = 1'b0;
      ld_addr_i   = '0;
      ld_data_i   = '0;

      @(posedge clk); #1;
      chk1("rst_arready", s_arrdy_o, 1'b0);
      chk1("rst_rvalid", s_rvalid_o, 1'b0);
      chkd("rst_rdata", s_rdata_o, 64'h0);
      chkr("rst_rresp", s_rresp_o, OKAY);
      repeat (4) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk1("rel_arready_pre", s_arrdy_o, 1'b0);
      @(posedge clk); #1;
      chk1("rel_arready_post", s_arrdy_o, 1'b1);
      chk1("rel_rvalid", s_rvalid_o, 1'b0);

      load(10'd5,    64'hDEAD_BEEF_0123_4567);
      load(10'd0,    64'h0011_2233_4455_6677);
      load(10'd1023, 64'hA5A5_5A5A_F00D_CAFE);
      load(10'd7,    64'h0);

      for (int i = 0; i < 8; i++) begin
         rd_txn(vecs[i].addr, 0, 1'b0, 10'd0, 64'h0, vecs[i].data, vecs[i].resp);
      end

      rd_txn(32'h28, 10, 1'b0, 10'd0, 64'h0, 64'hDEAD_BEEF_0123_4567, OKAY);

      rd_txn(32'h38, 0, 1'b1, 10'd7, 64'h1, 64'h0, OKAY);
      rd_txn(32'h38, 0, 1'b0, 10'd0, 64'h0, 64'h1, OKAY);

      s_rrdy_i    = 1'b0;
      s_araddr_i  = 32'h28;
      s_arvalid_i = 1'b1;
      chk1("mid_rst_arready_pre", s_arrdy_o, 1'b1);
      @(posedge clk); #1;
      s_arvalid_i = 1'b0;
      @(posedge clk); #1;
      chk1("mid_rst_in_resp", s_rvalid_o, 1'b1);
      rst_n = 1'b0;
      #1;
      chk1("mid_rst_rvalid", s_rvalid_o, 1'b0);
      chk1("mid_rst_arready", s_arrdy_o, 1'b0);
      chkd("mid_rst_rdata", s_rdata_o, 64'h0);
      @(posedge clk); #1;
      chk1("mid_rst_held_rvalid", s_rvalid_o, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk1("mid_rst_rel_arready", s_arrdy_o, 1'b1);
      chk1("mid_rst_rel_rvalid", s_rvalid_o, 1'b0);

      rd_txn(32'h28, 0, 1'b0, 10'd0, 64'h0, 64'hDEAD_BEEF_0123_4567, OKAY);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
